// File: rtl/huff_pkg.sv
// Shared types and sizing helpers for the canonical-Huffman stream decoder.
// Imported by the matcher and the top-level decoder.
package huff_pkg;

    typedef enum logic [1:0] {
        ST_CFG,
        ST_RUN,
        ST_DRAIN,
        ST_ERR
    } state_e;

    localparam logic CFG_SEL_COUNT = 1'b0;
    localparam logic CFG_SEL_SYM   = 1'b1;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int nb_w(input int in_w);
        return $clog2(in_w + 1);
    endfunction

endpackage

// File: rtl/huff_canon_match.sv
// Canonical first/offset derivation from per-length counts and
// smallest-length prefix match against the head of the bit buffer.
module huff_canon_match
    import huff_pkg::*;
#(
    parameter int MAX_LEN = 10,
    parameter int SYM_W   = 5,
    parameter int FILL_W  = 6
) (
    input  logic [MAX_LEN:1][SYM_W:0]      count,
    input  logic [MAX_LEN-1:0]             top_bits,
    input  logic [FILL_W-1:0]              fill,
    output logic                           hit,
    output logic [len_w(MAX_LEN)-1:0]      len,
    output logic [SYM_W-1:0]               idx
);

    localparam int LEN_W = len_w(MAX_LEN);
    localparam int CW    = (MAX_LEN > SYM_W + 1) ? MAX_LEN : SYM_W + 1;

    // Arithmetic is modulo 2^CW; only the low l bits of first[l] matter.
    always_comb begin
        logic [CW-1:0]    first_v;
        logic [CW-1:0]    prefix;
        logic [CW-1:0]    mask;
        logic [CW-1:0]    diff;
        logic [SYM_W-1:0] off_v;
        hit     = 1'b0;
        len     = '0;
        idx     = '0;
        first_v = '0;
        off_v   = '0;
        for (int l = 1; l <= MAX_LEN; l++) begin
            mask   = (CW'(1) << l) - CW'(1);
            prefix = CW'(top_bits >> (MAX_LEN - l));
            diff   = (prefix - first_v) & mask;
            if (!hit && fill >= FILL_W'(l) &&
                diff < CW'(count[l])) begin
                hit = 1'b1;
                len = LEN_W'(l);
                idx = off_v + SYM_W'(diff);
            end
            first_v = (first_v + CW'(count[l])) << 1;
            off_v   = off_v + SYM_W'(count[l]);
        end
    end

endmodule

// File: rtl/huffman_stream_decoder.sv
// Canonical-Huffman stream decoder: packed MSB-first words in, one
// (symbol, length) per cycle out, programmable tables, drain and error.
module huffman_stream_decoder
    import huff_pkg::*;
#(
    parameter int IN_W    = 8,
    parameter int MAX_LEN = 10,
    parameter int SYM_W   = 5,
    parameter int BUF_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_en,
    input  logic                        cfg_we,
    input  logic                        cfg_sel,
    input  logic [SYM_W-1:0]            cfg_addr,
    input  logic [SYM_W:0]              cfg_data,
    input  logic [IN_W-1:0]             in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    input  logic [nb_w(IN_W)-1:0]       in_nbits,
    output logic                        in_ready,
    output logic [SYM_W-1:0]            out_sym,
    output logic [len_w(MAX_LEN)-1:0]   out_len,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        done,
    output logic                        err
);

    localparam int LEN_W  = len_w(MAX_LEN);
    localparam int NB_W   = nb_w(IN_W);
    localparam int NSYM   = 1 << SYM_W;
    localparam int FILL_W = $clog2(BUF_W + 1);

    state_e                        state_q, state_d;
    logic [BUF_W-1:0]              bits_q, bits_d;
    logic [FILL_W-1:0]             fill_q, fill_d;
    logic                          out_valid_q, out_valid_d;
    logic [SYM_W-1:0]              out_sym_q, out_sym_d;
    logic [LEN_W-1:0]              out_len_q, out_len_d;
    logic                          done_q, done_d;
    logic                          err_q, err_d;
    logic [MAX_LEN:1][SYM_W:0]     count_q, count_d;
    logic [NSYM-1:0][SYM_W-1:0]    symtab_q, symtab_d;

    logic                          m_hit;
    logic [LEN_W-1:0]              m_len;
    logic [SYM_W-1:0]              m_idx;
    logic                          accept;
    logic                          consume;
    logic [FILL_W-1:0]             take;
    logic [FILL_W-1:0]             base;
    logic [NB_W-1:0]               nb;
    logic [IN_W-1:0]               word;

    huff_canon_match #(
        .MAX_LEN (MAX_LEN),
        .SYM_W   (SYM_W),
        .FILL_W  (FILL_W)
    ) u_match (
        .count    (count_q),
        .top_bits (bits_q[BUF_W-1 -: MAX_LEN]),
        .fill     (fill_q),
        .hit      (m_hit),
        .len      (m_len),
        .idx      (m_idx)
    );

    assign in_ready = (state_q == ST_RUN) &&
                      (fill_q <= FILL_W'(BUF_W - IN_W));

    always_comb begin
        state_d     = state_q;
        bits_d      = bits_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_len_d   = out_len_q;
        done_d      = 1'b0;
        err_d       = err_q;
        count_d     = count_q;
        symtab_d    = symtab_q;

        accept  = in_valid && in_ready;
        consume = (state_q == ST_RUN || state_q == ST_DRAIN) &&
                  m_hit && (!out_valid_q || out_ready);
        take    = consume ? FILL_W'(m_len) : '0;
        base    = fill_q - take;
        nb      = (in_last && in_nbits != '0) ? in_nbits : NB_W'(IN_W);
        // Bits past the valid count are zeroed so the buffer tail stays clean.
        word    = in_data & ~({IN_W{1'b1}} >> nb);

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (consume) begin
            out_valid_d = 1'b1;
            out_sym_d   = symtab_q[m_idx];
            out_len_d   = m_len;
        end

        bits_d = bits_q << take;
        fill_d = base;
        if (accept) begin
            bits_d = bits_d | ({word, {(BUF_W - IN_W){1'b0}}} >> base);
            fill_d = base + FILL_W'(nb);
        end

        unique case (state_q)
            ST_CFG: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!m_hit && fill_q >= FILL_W'(MAX_LEN)) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else if (accept && in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!m_hit && !out_valid_q) begin
                    done_d  = 1'b1;
                    bits_d  = '0;
                    fill_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_CFG;
            end
        endcase

        if (cfg_en) begin
            state_d     = ST_CFG;
            bits_d      = '0;
            fill_d      = '0;
            out_valid_d = 1'b0;
            out_sym_d   = '0;
            out_len_d   = '0;
            done_d      = 1'b0;
            err_d       = 1'b0;
            if (cfg_we) begin
                unique case (cfg_sel)
                    CFG_SEL_COUNT: begin
                        for (int l = 1; l <= MAX_LEN; l++) begin
                            if (cfg_addr == SYM_W'(l)) begin
                                count_d[l] = cfg_data;
                            end
                        end
                    end
                    CFG_SEL_SYM: begin
                        symtab_d[cfg_addr] = cfg_data[SYM_W-1:0];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_CFG;
            bits_q      <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_len_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
            symtab_q    <= '0;
        end else begin
            state_q     <= state_d;
            bits_q      <= bits_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_len_q   <= out_len_d;
            done_q      <= done_d;
            err_q       <= err_d;
            count_q     <= count_d;
            symtab_q    <= symtab_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign out_len   = out_len_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
